mux_share_arbiter: RTL and testbench
====================================

Name: mux_share_arbiter

Overview:
- Round-robin arbiter that shares a single WIDTH-bit 2:1 data mux between two requesters, A and B.
- Owns the mux select, issues grants, and registers the selected data onto a shared output with a valid strobe.
- A hold limit stops one requester from monopolising the mux while the other is waiting.
- Sits between two producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_HOLD, 4, maximum consecutive beats one owner may transfer while the other requests. Must be >= 1; 1 gives strict alternation.

Ports:
- clk  input  1  system clock; single clock domain, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A wants the mux; held high for as long as A has beats to send.
- data_a  input  WIDTH  requester A data, sampled when a beat occurs.
- req_b  input  1  requester B request.
- data_b  input  WIDTH  requester B data.
- gnt_a  output  1  A owns the mux this cycle.
- gnt_b  output  1  B owns the mux this cycle.
- sel  output  1  mux select: 0 selects A, 1 selects B.
- data_out  output  WIDTH  registered mux output.
- valid_out  output  1  data_out holds a beat this cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE, gnt_a=0, gnt_b=0, sel=0, data_out=0, valid_out=0, hold_cnt=0.
  - last_owner=B, so A wins the first contested arbitration.
  - Asserting reset mid-transfer clears everything immediately. Any beat in flight is lost and no valid_out is produced for it.
- States: IDLE, GRANT_A, GRANT_B.
  - gnt_a = (state==GRANT_A); gnt_b = (state==GRANT_B). Decoded from registered state; never combinational from req.
  - sel = 0 in GRANT_A, 1 in GRANT_B. In IDLE, sel holds its last value.
- Beat: a cycle where (gnt_a & req_a) or (gnt_b & req_b).
  - The next edge loads data_out with the granted requester's data and sets valid_out=1.
  - Otherwise valid_out=0 and data_out holds its value.
  - Latency: req rises in cycle n -> grant in cycle n+1 -> first valid_out in cycle n+2. Then one beat per cycle while the request is held.
- IDLE transitions:
  - Only req_a -> GRANT_A.
  - Only req_b -> GRANT_B.
  - Both -> grant the requester that is not last_owner.
  - Neither -> stay in IDLE.
- GRANT_X transitions (Y is the other requester):
  - req_X=0 -> go to GRANT_Y if req_Y=1, else IDLE. No beat occurs that cycle.
  - req_X=1, req_Y=1 and hold_cnt==MAX_HOLD-1 -> beat, then go to GRANT_Y (forced rotation).
  - Otherwise -> beat and stay in GRANT_X.
- On every grant change:
  - hold_cnt clears to 0.
  - last_owner updates to the new owner.
  - sel switches on the same edge as the grant.
- hold_cnt:
  - Increments on each beat while the other requester is high.
  - Saturates at MAX_HOLD-1 while the other requester is low, so an uncontested owner streams indefinitely.
  - Once the other requester rises, rotation happens on that requester's first beat at the limit.
  - Width is clog2(MAX_HOLD) bits, minimum 1.
- Simultaneous events:
  - Owner drops req in the same cycle the other raises req -> handover with no idle cycle. The new grant appears next cycle.
  - Both requests drop together -> IDLE.
- Data path: data_x is sampled only on beats. Data presented without a grant is ignored.
- No bubble is inserted on a handover between owners: valid_out can be high on consecutive cycles from different owners.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then idle inputs -> all outputs 0, state IDLE, sel=0.
- Single requester: req_a=1 for 6 cycles with data_a=0x10..0x15, req_b=0 -> gnt_a from cycle 1; valid_out cycles 2-7 carrying 0x10..0x15; sel=0 throughout; hold_cnt saturates at 3 with no rotation.
- Contention, MAX_HOLD=4: req_a and req_b both held high from cycle 0 -> A is granted first. Grant pattern is A,A,A,A,B,B,B,B,A...; valid_out continuous from cycle 2; sel toggles every 4 cycles.
- Early release: B granted, req_b drops after 2 beats while req_a=1 -> gnt_a asserted the next cycle; exactly 2 beats with B data on data_out; no idle gap.
- Async reset mid-burst: rst_n pulsed low between clock edges during a GRANT_B beat -> gnt_b, valid_out and sel go to 0 immediately without waiting for an edge; after release with both requesting, A is granted first.
- MAX_HOLD=1: both requesting continuously -> grants alternate A,B,A,B every cycle; data_out alternates data_a and data_b.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 2:1 mux between requesters A and B.
// Registers the selected beat onto data_out/valid_out; MAX_HOLD bounds contested ownership.
module mux_share_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    localparam int unsigned   CW         = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);
    localparam logic          OWNER_A    = 1'b0;
    localparam logic          OWNER_B    = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_next;
    logic            last_owner;
    logic            last_next;
    logic            beat;
    logic            sel_next;
    logic [WIDTH-1:0] beat_data;

    // State, hold counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= OWNER_B;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            sel        <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            last_owner <= last_next;
            gnt_a      <= (state_next == GRANT_A);
            gnt_b      <= (state_next == GRANT_B);
            sel        <= sel_next;
            valid_out  <= beat;
            if (beat) begin
                data_out <= beat_data;
            end
        end
    end

    // Next-state, beat detection and hold accounting.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        last_next  = last_owner;
        beat       = 1'b0;
        beat_data  = (state == GRANT_B) ? data_b : data_a;

        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_next = (last_owner == OWNER_A) ? GRANT_B : GRANT_A;
                end else if (req_a) begin
                    state_next = GRANT_A;
                end else if (req_b) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!req_a) begin
                    state_next = req_b ? GRANT_B : IDLE;
                end else begin
                    beat = 1'b1;
                    if (req_b && (hold_cnt == HOLD_LIMIT)) begin
                        state_next = GRANT_B;
                    end else if (hold_cnt != HOLD_LIMIT) begin
                        hold_next = hold_cnt + CW'(1);
                    end
                end
            end
            GRANT_B: begin
                if (!req_b) begin
                    state_next = req_a ? GRANT_A : IDLE;
                end else begin
                    beat = 1'b1;
                    if (req_a && (hold_cnt == HOLD_LIMIT)) begin
                        state_next = GRANT_A;
                    end else if (hold_cnt != HOLD_LIMIT) begin
                        hold_next = hold_cnt + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Any ownership change restarts the hold window; IDLE keeps last_owner.
        if (state_next != state) begin
            hold_next = '0;
        end
        if ((state_next == GRANT_A) && (state != GRANT_A)) begin
            last_next = OWNER_A;
        end
        if ((state_next == GRANT_B) && (state != GRANT_B)) begin
            last_next = OWNER_B;
        end

        case (state_next)
            GRANT_A: sel_next = 1'b0;
            GRANT_B: sel_next = 1'b1;
            default: sel_next = sel;
        endcase
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter: vector table for MAX_HOLD=4 plus
// hand sequences for async reset mid-burst and MAX_HOLD=1 alternation.
module tb_mux_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic       req_b;
    logic [7:0] data_a;
    logic [7:0] data_b;

    logic       gnt_a0, gnt_b0, sel0, valid0;
    logic [7:0] dout0;
    logic       gnt_a1, gnt_b1, sel1, valid1;
    logic [7:0] dout1;

    int total;
    int bad;

    mux_share_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .gnt_a(gnt_a0), .gnt_b(gnt_b0), .sel(sel0),
        .data_out(dout0), .valid_out(valid0)
    );

    mux_share_arbiter #(.WIDTH(8), .MAX_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1),
        .data_out(dout1), .valid_out(valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ra;
        logic [7:0] da;
        logic       rb;
        logic [7:0] db;
        logic       ga;
        logic       gb;
        logic       s;
        logic       v;
        logic [7:0] d;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic ra, input logic [7:0] da,
                       input logic rb, input logic [7:0] db,
                       input logic ga, input logic gb, input logic s,
                       input logic v, input logic [7:0] d);
        vec_t t;
        t.rst = rst; t.ra = ra; t.da = da; t.rb = rb; t.db = db;
        t.ga = ga; t.gb = gb; t.s = s; t.v = v; t.d = d;
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;
        repeat (3) tick();
        check("reset u0 outputs", 32'({gnt_a0, gnt_b0, sel0, valid0, dout0}), 32'd0);
        check("reset u1 outputs", 32'({gnt_a1, gnt_b1, sel1, valid1, dout1}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle u0 outputs", 32'({gnt_a0, gnt_b0, sel0, valid0, dout0}), 32'd0);
    endtask

    initial begin
        logic [7:0] ea;
        logic [7:0] eb;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;

        // Single requester A, B data present but ignored.
        add(1, 1, 8'h0F, 0, 8'hEE, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            add(0, 1, 8'(8'h10 + i), 0, 8'hEE, 1, 0, 0, 1, 8'(8'h10 + i));
        end
        add(0, 0, 8'h00, 0, 8'hEE, 0, 0, 0, 0, 8'h15);
        add(0, 0, 8'h00, 0, 8'hEE, 0, 0, 0, 0, 8'h15);

        // Contention with MAX_HOLD=4: A x4, B x4, then A again.
        add(1, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00);
        add(0, 1, 8'hA1, 1, 8'hB1, 1, 0, 0, 1, 8'hA1);
        add(0, 1, 8'hA2, 1, 8'hB2, 1, 0, 0, 1, 8'hA2);
        add(0, 1, 8'hA3, 1, 8'hB3, 1, 0, 0, 1, 8'hA3);
        add(0, 1, 8'hA4, 1, 8'hB4, 0, 1, 1, 1, 8'hA4);
        add(0, 1, 8'hA5, 1, 8'hB5, 0, 1, 1, 1, 8'hB5);
        add(0, 1, 8'hA6, 1, 8'hB6, 0, 1, 1, 1, 8'hB6);
        add(0, 1, 8'hA7, 1, 8'hB7, 0, 1, 1, 1, 8'hB7);
        add(0, 1, 8'hA8, 1, 8'hB8, 1, 0, 0, 1, 8'hB8);
        add(0, 1, 8'hA9, 1, 8'hB9, 1, 0, 0, 1, 8'hA9);

        // A releases to B, B sends 2 beats then releases straight back to A.
        add(0, 0, 8'h00, 1, 8'hC0, 0, 1, 1, 0, 8'hA9);
        add(0, 1, 8'h00, 1, 8'hC1, 0, 1, 1, 1, 8'hC1);
        add(0, 1, 8'h00, 1, 8'hC2, 0, 1, 1, 1, 8'hC2);
        add(0, 1, 8'h00, 0, 8'hC3, 1, 0, 0, 0, 8'hC2);
        add(0, 1, 8'hD0, 0, 8'h00, 1, 0, 0, 1, 8'hD0);
        add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'hD0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req_a  = vecs[i].ra;
            data_a = vecs[i].da;
            req_b  = vecs[i].rb;
            data_b = vecs[i].db;
            tick();
            check($sformatf("row%0d gnt_a", i), 32'(gnt_a0), 32'(vecs[i].ga));
            check($sformatf("row%0d gnt_b", i), 32'(gnt_b0), 32'(vecs[i].gb));
            check($sformatf("row%0d sel", i), 32'(sel0), 32'(vecs[i].s));
            check($sformatf("row%0d valid_out", i), 32'(valid0), 32'(vecs[i].v));
            check($sformatf("row%0d data_out", i), 32'(dout0), 32'(vecs[i].d));
        end

        // Async reset asserted between edges during a B beat.
        do_reset();
        req_b  = 1'b1;
        data_b = 8'h71;
        tick();
        check("async pre gnt_b", 32'(gnt_b0), 32'd1);
        data_b = 8'h72;
        tick();
        check("async pre valid", 32'({valid0, dout0}), 32'({1'b1, 8'h72}));
        data_b = 8'h73;
        #2;
        rst_n = 1'b0;
        #1;
        check("async gnt_b cleared", 32'(gnt_b0), 32'd0);
        check("async valid cleared", 32'(valid0), 32'd0);
        check("async sel cleared", 32'(sel0), 32'd0);
        check("async data cleared", 32'(dout0), 32'd0);
        req_a  = 1'b1;
        data_a = 8'h81;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-reset gnt_a first", 32'({gnt_a0, gnt_b0}), 32'b10);
        data_a = 8'h82;
        tick();
        check("post-reset first beat", 32'({valid0, dout0}), 32'({1'b1, 8'h82}));

        // MAX_HOLD=1 instance: strict alternation under continuous contention.
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            data_a = 8'(8'h50 + k);
            data_b = 8'(8'h60 + k);
            tick();
            check($sformatf("alt%0d grants", k), 32'({gnt_a1, gnt_b1}),
                  (k % 2 == 1) ? 32'b10 : 32'b01);
            if (k >= 2) begin
                ea = 8'(8'h50 + k);
                eb = 8'(8'h60 + k);
                check($sformatf("alt%0d data_out", k), 32'({valid1, dout1}),
                      32'({1'b1, (k % 2 == 0) ? ea : eb}));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
